rtmc_spi_reg_bridge: RTL and testbench

SPI peripheral front end that turns SPI frames from the external host into register-bus transactions toward the register file (reg_if initiator side). SPI inputs are oversampled in the system clock domain, so no second clock domain exists. Each frame carries one command byte, one address byte and one 16-bit data word. Register reads and writes are issued as single-cycle strobes, and the bridge waits for the responder's ack.

---
 rtl/rtmc_pkg.sv | 21 ++
 rtl/rtmc_spi_sync.sv | 36 +++
 rtl/rtmc_spi_reg_bridge.sv | 185 ++++++++++++++++++
 tb/tb_rtmc_spi_reg_bridge.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtmc_pkg.sv
// Shared types and constants for the rtmc SPI-to-register bridge.
package rtmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_WR_WAIT,
        ST_RD_WAIT,
        ST_RDATA,
        ST_DRAIN
    } bridge_state_t;

    localparam int CMD_WR_BIT      = 7;
    localparam int CMD_CLR_BIT     = 6;
    localparam int CMD_BITS        = 8;
    localparam int HDR_BITS        = 16;
    localparam int FRAME_BITS      = 32;
    localparam int ACK_TIMEOUT_DEF = 15;

endpackage

// File: rtl/rtmc_spi_sync.sv
// Two-flop synchronisers for the SPI pins plus sclk edge detection in the clk domain.
module rtmc_spi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sclk,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_sync,
    output logic mosi_sync
);

    logic [2:0] sclk_ff;
    logic [1:0] cs_ff;
    logic [1:0] mosi_ff;

    // cs resets to the deasserted level so reset itself never looks like a frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_ff <= 3'b000;
            cs_ff   <= 2'b11;
            mosi_ff <= 2'b00;
        end else begin
            sclk_ff <= {sclk_ff[1:0], spi_sclk};
            cs_ff   <= {cs_ff[0], spi_cs};
            mosi_ff <= {mosi_ff[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_ff[1] & ~sclk_ff[2];
    assign sclk_fall = ~sclk_ff[1] & sclk_ff[2];
    assign cs_n_sync = cs_ff[1];
    assign mosi_sync = mosi_ff[1];

endmodule

// File: rtl/rtmc_spi_reg_bridge.sv
// SPI mode-0 peripheral that converts 32-bit cmd/addr/data frames into register-bus strobes.
//
// state    | meaning
// IDLE     | cs high, waiting for a frame
// HDR      | shifting cmd + addr bytes
// WDATA    | shifting 16-bit write data
// WR_WAIT  | reg_wr issued, waiting for ack or timeout
// RD_WAIT  | reg_rd issued, waiting for ack or timeout
// RDATA    | shifting read data out on miso
// DRAIN    | frame done, ignoring extra bits until cs rises
module rtmc_spi_reg_bridge
    import rtmc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdat,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdat,
    input  logic              reg_ack,
    output logic              err,
    output logic              busy
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int CNT_W  = 6;

    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_n_sync;
    logic              mosi_sync;

    bridge_state_t     state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_next;
    logic              cmd_wr;
    logic              ack_expired;

    rtmc_spi_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_n_sync (cs_n_sync),
        .mosi_sync (mosi_sync)
    );

    assign rx_next     = {rx_sr[DATA_W-2:0], mosi_sync};
    assign ack_expired = (wait_cnt == WAIT_W'(ACK_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            cmd_wr      <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            reg_addr    <= '0;
            reg_wdat    <= '0;
            reg_wr      <= 1'b0;
            reg_rd      <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            if (state != ST_IDLE && cs_n_sync) begin
                state       <= ST_IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!cs_n_sync) begin
                            state       <= ST_HDR;
                            bit_cnt     <= '0;
                            rx_sr       <= '0;
                            spi_miso    <= 1'b0;
                            spi_miso_oe <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                    ST_HDR: begin
                        if (sclk_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                                cmd_wr <= rx_next[CMD_WR_BIT];
                                if (rx_next[CMD_CLR_BIT]) err <= 1'b0;
                            end
                            if (bit_cnt == CNT_W'(HDR_BITS - 1)) begin
                                reg_addr <= rx_next[ADDR_W-1:0];
                                if (cmd_wr) begin
                                    state <= ST_WDATA;
                                end else begin
                                    reg_rd   <= 1'b1;
                                    wait_cnt <= '0;
                                    state    <= ST_RD_WAIT;
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                                reg_wdat <= rx_next;
                                reg_wr   <= 1'b1;
                                wait_cnt <= '0;
                                state    <= ST_WR_WAIT;
                            end
                        end
                    end
                    ST_WR_WAIT: begin
                        if (reg_ack) begin
                            state <= ST_DRAIN;
                        end else if (ack_expired) begin
                            err   <= 1'b1;
                            state <= ST_DRAIN;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (sclk_rise) bit_cnt <= bit_cnt + 1'b1;
                        if (reg_ack) begin
                            tx_sr    <= reg_rdat;
                            spi_miso <= reg_rdat[DATA_W-1];
                            state    <= ST_RDATA;
                        end else if (ack_expired) begin
                            err      <= 1'b1;
                            tx_sr    <= '0;
                            spi_miso <= 1'b0;
                            state    <= ST_RDATA;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_RDATA: begin
                        // The fall after the last header bit keeps the MSB already on miso
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (sclk_fall) begin
                            if (bit_cnt >= CNT_W'(FRAME_BITS)) begin
                                spi_miso <= 1'b0;
                                state    <= ST_DRAIN;
                            end else if (bit_cnt > CNT_W'(HDR_BITS)) begin
                                tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                                spi_miso <= tx_sr[DATA_W-2];
                            end
                        end
                    end
                    ST_DRAIN: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtmc_spi_reg_bridge.sv
// Scoreboard bench: an SPI host model drives frames, a responder model acks, a monitor checks strobes.
module tb_rtmc_spi_reg_bridge;

    localparam int HALF    = 8;
    localparam int GAP     = 40;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sclk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdat;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdat = 16'h0000;
    logic        reg_ack  = 1'b0;
    logic        err;
    logic        busy;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          resp_delay = 0;
    int          pend = 0;
    bit          pending = 0;
    bit          err_model = 0;
    int          cyc = 0;
    int          strobe_cyc = 0;
    int          err_rise_cyc = 0;
    logic        err_prev = 1'b0;

    rtmc_spi_reg_bridge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sclk    (spi_sclk),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_addr    (reg_addr),
        .reg_wdat    (reg_wdat),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdat    (reg_rdat),
        .reg_ack     (reg_ack),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        cyc++;
        if (err === 1'b1 && err_prev !== 1'b1) err_rise_cyc = cyc;
        err_prev = err;
    end

    // Strobe monitor: every cycle with a strobe must match the next expected transaction
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (reg_wr === 1'b1 || reg_rd === 1'b1)) begin
            txn_t t;
            strobe_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=%h, none expected", reg_wr, reg_rd, reg_addr);
            end else begin
                t = exp_q.pop_front();
                if (reg_wr !== t.wr || reg_rd !== !t.wr || reg_addr !== t.addr ||
                    (t.wr && reg_wdat !== t.data)) begin
                    errors++;
                    $display("FAIL strobe: got wr=%0b rd=%0b addr=%h wdat=%h, want wr=%0b addr=%h wdat=%h",
                             reg_wr, reg_rd, reg_addr, reg_wdat, t.wr, t.addr, t.data);
                end
            end
        end
    end

    // Responder: acks resp_delay cycles after the strobe cycle; negative means never
    always @(negedge clk) begin
        reg_ack  = 1'b0;
        reg_rdat = 16'($urandom);
        if (pending) begin
            if (pend == 0) begin
                reg_ack  = 1'b1;
                reg_rdat = mem[reg_addr];
                pending  = 0;
            end else begin
                pend--;
            end
        end
        if (rst_n === 1'b1 && (reg_wr === 1'b1 || reg_rd === 1'b1) && resp_delay >= 0) begin
            if (resp_delay == 0) begin
                reg_ack  = 1'b1;
                reg_rdat = mem[reg_addr];
            end else begin
                pending = 1;
                pend    = resp_delay - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [15:0] data,
                             input int nbits, input bit end_frame,
                             output logic [15:0] rd, output bit miso_bad, output logic [1:0] start_st);
        logic [31:0] word;
        word     = {cmd, addr, data};
        rd       = '0;
        miso_bad = 0;
        start_st = 2'b00;
        spi_cs   = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 32) ? word[31-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            if (i == 0) start_st = {busy, spi_miso_oe};
            if (i >= 16 && i < 32 && !cmd[7]) rd[31-i] = spi_miso;
            else if (spi_miso !== 1'b0) miso_bad = 1;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
            if (i == 15) repeat (GAP) @(negedge clk);
        end
        if (end_frame) begin
            repeat (GAP) @(negedge clk);
            spi_cs = 1'b1;
            repeat (GAP) @(negedge clk);
        end
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [15:0] data,
                            input int nbits, input int delay);
        bit          full;
        bit          miso_bad;
        logic [15:0] rd;
        logic [15:0] exp_rd;
        logic [1:0]  start_st;
        txn_t        t;
        resp_delay = delay;
        full = cmd[7] ? (nbits >= 32) : (nbits >= 16);
        exp_rd = (delay < 0) ? 16'h0000 : mem[addr];
        if (full) begin
            t.wr = cmd[7]; t.addr = addr; t.data = data;
            exp_q.push_back(t);
            if (cmd[7]) mem[addr] = data;
        end
        if (nbits >= 8 && cmd[6]) err_model = 0;
        if (full && delay < 0) err_model = 1;
        spi_frame(cmd, addr, data, nbits, 1'b1, rd, miso_bad, start_st);
        check("busy_oe_in_frame", 32'(start_st), 32'h3);
        check("miso_zero_outside_data", 32'(miso_bad), 32'h0);
        if (!cmd[7] && nbits >= 32) check("read_data", 32'(rd), 32'(exp_rd));
        check("err", 32'(err), 32'(err_model));
        check("busy_oe_after", {30'h0, busy, spi_miso_oe}, 32'h0);
        check("strobe_count", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] rd;
        bit          miso_bad;
        logic [1:0]  st;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rst_n = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", {spi_miso, spi_miso_oe, reg_wr, reg_rd, err, busy, reg_addr, reg_wdat}, 32'h0);
        rst_n = 1'b1;
        repeat (GAP) @(negedge clk);

        do_frame(8'h80, 8'h12, 16'hBEEF, 32, 1);
        check("hold_addr_wdat", {8'h0, reg_addr, reg_wdat}, 32'h0012BEEF);

        mem[8'h34] = 16'hA5C3;
        do_frame(8'h00, 8'h34, 16'h0000, 32, 2);

        do_frame(8'h00, 8'h56, 16'h0000, 32, -1);
        check("err_timeout_latency", 32'(err_rise_cyc - strobe_cyc), 32'(TIMEOUT + 1));
        do_frame(8'h40, 8'h21, 16'h0000, 32, 1);

        do_frame(8'h80, 8'h33, 16'h1234, 20, 1);
        do_frame(8'h80, 8'h05, 16'h0001, 32, 0);

        resp_delay = 1;
        spi_frame(8'h80, 8'h77, 16'hC0DE, 24, 1'b0, rd, miso_bad, st);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_mid_frame", {spi_miso, spi_miso_oe, reg_wr, reg_rd, err, busy, reg_addr, reg_wdat}, 32'h0);
        rst_n = 1'b1;
        err_model = 0;
        spi_cs = 1'b1;
        repeat (GAP) @(negedge clk);
        check("strobe_after_reset", 32'(exp_q.size()), 32'h0);
        do_frame(8'h80, 8'h09, 16'h5A5A, 32, 3);

        do_frame(8'h80, 8'h44, 16'h7E81, 40, 2);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] cmd;
            int         nbits;
            int         delay;
            cmd   = {1'($urandom), ($urandom_range(0, 3) == 0), 6'($urandom)};
            nbits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 31)) : 32 + int'($urandom_range(0, 8));
            delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            do_frame(cmd, 8'($urandom), 16'($urandom), nbits, delay);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
